// File: rtl/timer_ctrl.sv
// timer_ctrl: start/pause/clear sequencing and period compare for an external counter chain.
// Optional prescaler: define TIMER_CTRL_PRESCALE_EN to add cfg_presc and tick qualification.
//
// state | meaning
// IDLE  | chain stopped, configuration writes accepted
// CLEAR | one-cycle synchronous clear of the chain
// RUN   | counting, compare cnt_val against period
// PAUSE | count held, waiting for resume or abort
module timer_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         cfg_wr,
  input  logic [W-1:0] cfg_period,
  input  logic         cfg_mode,
`ifdef TIMER_CTRL_PRESCALE_EN
  input  logic [7:0]   cfg_presc,
`endif
  input  logic         start,
  input  logic         stop,
  input  logic         irq_ack,
  input  logic [W-1:0] cnt_val,
  output logic         cten,
  output logic         cnt_clr_b,
  output logic         busy,
  output logic         expire,
  output logic         irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t       state_q;
  logic [W-1:0] period_q;
  logic         mode_q;
  logic         irq_q;
  logic         tick;
  logic         match;

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [7:0] presc_q;
  logic [7:0] pcnt_q;

  // Down-counter reloads on terminal count; held outside RUN so PAUSE keeps phase.
  always_ff @(posedge clk) begin
    if (clr) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      if (state_q == S_IDLE && cfg_wr) presc_q <= cfg_presc;
      if (state_q == S_CLEAR)
        pcnt_q <= presc_q;
      else if (state_q == S_RUN)
        pcnt_q <= (pcnt_q == 8'd0) ? presc_q : pcnt_q - 8'd1;
    end
  end

  assign tick = (pcnt_q == 8'd0);
`else
  assign tick = 1'b1;
`endif

  assign match = (state_q == S_RUN) && tick && (cnt_val == period_q);
  assign irq   = irq_q;

  always_comb begin
    cten      = 1'b0;
    cnt_clr_b = 1'b1;
    expire    = 1'b0;
    busy      = 1'b0;
    if (clr) begin
      cnt_clr_b = 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          cnt_clr_b = 1'b0;
          busy      = 1'b1;
        end
        S_RUN: begin
          busy = 1'b1;
          if (match) begin
            expire = 1'b1;
            // Periodic re-clears the chain in the match cycle; one-shot leaves it at period.
            if (mode_q) cnt_clr_b = 1'b0;
            else        busy      = 1'b0;
          end else begin
            cten = tick & ~stop;
          end
        end
        S_PAUSE: busy = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      period_q <= '0;
      mode_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= expire | (irq_q & ~irq_ack);
      case (state_q)
        S_IDLE: begin
          if (cfg_wr) begin
            period_q <= cfg_period;
            mode_q   <= cfg_mode;
          end
          // Start is judged against the period held before any same-cycle write.
          if (start && !stop && (period_q != '0)) state_q <= S_CLEAR;
        end
        S_CLEAR: state_q <= stop ? S_IDLE : S_RUN;
        S_RUN: begin
          if (match) begin
            if (!mode_q)   state_q <= S_IDLE;
            else if (stop) state_q <= S_PAUSE;
          end else if (stop) begin
            state_q <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (stop)       state_q <= S_IDLE;
          else if (start) state_q <= S_RUN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
